// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the tournament branch predictor
package bp_pkg;
    typedef enum logic [1:0] {
        BP_STATIC = 2'd0,
        BP_GLOBAL = 2'd1,
        BP_LOCAL  = 2'd2,
        BP_TOURN  = 2'd3
    } bp_mode_e;
    localparam int IDX_MAX = 16;
    localparam int CLS_MAX = 4;
    // Widest supported index/class fields; each user slices down to its own width.
    typedef struct packed {
        logic               valid;
        logic [CLS_MAX-1:0] cls;
        logic [IDX_MAX-1:0] gidx;
        logic [IDX_MAX-1:0] lidx;
        logic [IDX_MAX-1:0] midx;
        logic               g_pred;
        logic               l_pred;
        logic               final_pred;
        logic               imm_sign;
    } bp_meta_t;
    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] max);
        return (v == max) ? v : v + 8'd1;
    endfunction
    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'd0) ? v : v - 8'd1;
    endfunction
endpackage

// File: rtl/bp_pht.sv
// bp_pht: table of saturating counters, async read port, clocked train port
// Ports: clk, rst_n (async active-low); rd_idx/rd_cnt read port;
//        wr_en/wr_idx/wr_up train port (wr_up=1 counts up, else down).
module bp_pht import bp_pkg::*; #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 2,
    parameter int INIT  = 0
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_up
);
    localparam logic [7:0] MAX = 8'((1 << CNT_W) - 1);
    logic [CNT_W-1:0] cnt [2**IDX_W];
    assign rd_cnt = cnt[rd_idx];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < 2**IDX_W; i++) cnt[i] <= CNT_W'(INIT);
        else if (wr_en)
            cnt[wr_idx] <= CNT_W'(wr_up ? sat_inc(8'(cnt[wr_idx]), MAX) : sat_dec(8'(cnt[wr_idx])));
endmodule

// File: rtl/tournament_bp.sv
// tournament_bp: static/global/local/tournament conditional-branch predictor
// Ports: clk, rst_n (async active-low); stall, flush; mode;
//        predict: pred_valid, pred_pc, pred_class, pred_imm_sign -> pred_taken (comb);
//        resolve: res_valid, res_taken -> res_mispredict (comb);
//        perf_branches, perf_mispred saturating counters.
module tournament_bp import bp_pkg::*; #(
    parameter int GHIST_W    = 6,
    parameter int LHIST_W    = 5,
    parameter int PC_IDX_W   = 4,
    parameter int CNT_W      = 2,
    parameter int CNT_INIT   = 0,
    parameter int META_W     = 2,
    parameter int N_CLASS    = 6,
    parameter int PIPE_DEPTH = 2,
    localparam int CLS_W     = $clog2(N_CLASS)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic [1:0]       mode,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    input  logic [CLS_W-1:0] pred_class,
    input  logic             pred_imm_sign,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             res_mispredict,
    output logic [31:0]      perf_branches,
    output logic [31:0]      perf_mispred
);
    localparam int GI_W = GHIST_W + PC_IDX_W;
    localparam int LI_W = LHIST_W + PC_IDX_W;
    logic [GHIST_W-1:0] ghr_spec, ghr_commit, ghr_commit_n;
    logic [N_CLASS-1:0][LHIST_W-1:0] lhr_spec, lhr_commit, lhr_commit_n;
    bp_meta_t pipe [PIPE_DEPTH];
    bp_meta_t last, entry;
    logic [PC_IDX_W-1:0] pc_idx;
    logic [GI_W-1:0] gidx;
    logic [LI_W-1:0] lidx;
    logic [CNT_W-1:0] g_cnt;
    logic [N_CLASS-1:0][CNT_W-1:0] l_cnt;
    logic [META_W-1:0] m_cnt;
    logic g_pred, l_pred, final_pred, accept, res_eff, restore, unused_bits;
    assign pc_idx = pred_pc[PC_IDX_W+1:2];
    assign gidx = {ghr_spec, pc_idx};
    assign lidx = {lhr_spec[pred_class], pc_idx};
    assign g_pred = g_cnt[CNT_W-1];
    assign l_pred = l_cnt[pred_class][CNT_W-1];
    assign final_pred = mode == BP_STATIC ? pred_imm_sign :
                        mode == BP_GLOBAL ? g_pred :
                        mode == BP_LOCAL  ? l_pred :
                        m_cnt[META_W-1]   ? g_pred : l_pred;
    assign pred_taken = pred_valid & final_pred;
    assign last = pipe[PIPE_DEPTH-1];
    assign res_eff = res_valid & ~stall & last.valid;
    assign res_mispredict = res_eff & (res_taken != last.final_pred);
    assign accept = pred_valid & ~stall & ~flush & ~res_mispredict;
    assign restore = res_mispredict | flush;
    assign entry = '{valid: 1'b1, cls: CLS_MAX'(pred_class), gidx: IDX_MAX'(gidx),
                     lidx: IDX_MAX'(lidx), midx: IDX_MAX'(pc_idx), g_pred: g_pred,
                     l_pred: l_pred, final_pred: final_pred, imm_sign: pred_imm_sign};
    assign unused_bits = ^{pred_pc, last};
    // Committed histories as they will be after this cycle's resolve; also the restore target.
    always_comb begin
        ghr_commit_n = ghr_commit;
        lhr_commit_n = lhr_commit;
        if (res_eff) begin
            ghr_commit_n = {ghr_commit[GHIST_W-2:0], res_taken};
            lhr_commit_n[last.cls[CLS_W-1:0]] = {lhr_commit[last.cls[CLS_W-1:0]][LHIST_W-2:0], res_taken};
        end
    end
    bp_pht #(.IDX_W(GI_W), .CNT_W(CNT_W), .INIT(CNT_INIT)) u_gpht (
        .clk(clk), .rst_n(rst_n), .rd_idx(gidx), .rd_cnt(g_cnt),
        .wr_en(res_eff), .wr_idx(last.gidx[GI_W-1:0]), .wr_up(res_taken));
    // Meta counts toward global when global alone was right, toward local when local alone was.
    bp_pht #(.IDX_W(PC_IDX_W), .CNT_W(META_W), .INIT(2**(META_W-1))) u_meta (
        .clk(clk), .rst_n(rst_n), .rd_idx(pc_idx), .rd_cnt(m_cnt),
        .wr_en(res_eff & (last.g_pred != last.l_pred)), .wr_idx(last.midx[PC_IDX_W-1:0]),
        .wr_up(last.g_pred == res_taken));
    for (genvar c = 0; c < N_CLASS; c++) begin : g_lpht
        bp_pht #(.IDX_W(LI_W), .CNT_W(CNT_W), .INIT(CNT_INIT)) u_lpht (
            .clk(clk), .rst_n(rst_n), .rd_idx(lidx), .rd_cnt(l_cnt[c]),
            .wr_en(res_eff & (last.cls == CLS_MAX'(c))), .wr_idx(last.lidx[LI_W-1:0]),
            .wr_up(res_taken));
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ghr_spec <= '0;
            ghr_commit <= '0;
            lhr_spec <= '0;
            lhr_commit <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
            perf_branches <= '0;
            perf_mispred <= '0;
        end else begin
            ghr_commit <= ghr_commit_n;
            lhr_commit <= lhr_commit_n;
            if (res_eff && perf_branches != '1) perf_branches <= perf_branches + 32'd1;
            if (res_mispredict && perf_mispred != '1) perf_mispred <= perf_mispred + 32'd1;
            if (restore) begin
                ghr_spec <= ghr_commit_n;
                lhr_spec <= lhr_commit_n;
                for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
            end else if (!stall) begin
                pipe[0] <= accept ? entry : '0;
                for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
                if (accept) begin
                    ghr_spec <= {ghr_spec[GHIST_W-2:0], pred_taken};
                    lhr_spec[pred_class] <= {lhr_spec[pred_class][LHIST_W-2:0], pred_taken};
                end
            end
        end
endmodule

// File: doc/tournament_bp.md
# tournament_bp

Parametrised tournament conditional-branch predictor that replaces the fixed six-class predictor in the fetch/decode front end. It provides a static, global, local or tournament prediction for one conditional branch per cycle and updates histories speculatively. It tracks in-flight predictions in an internal metadata pipeline of configurable depth, and trains counters non-speculatively at resolve. Histories roll back to committed state on mispredict or external flush.

## Interface
- `GHIST_W`, 6, global history length
- `LHIST_W`, 5, per-class local history length
- `PC_IDX_W`, 4, PC bits used in indices, taken from `pc[PC_IDX_W+1:2]`
- `CNT_W`, 2, PHT saturating counter width
- `CNT_INIT`, 0, PHT reset value
- `META_W`, 2, meta counter width
- `N_CLASS`, 6, branch classes (beq..bgeu), one local history and local PHT each
- `PIPE_DEPTH`, 2, stages from predict to resolve, ≥1
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  pipeline hold; metadata pipe and histories frozen, resolve ignored
- `flush`  in  1  external flush; kills all in-flight entries, restores histories
- `mode`  in  2  0 static, 1 global, 2 local, 3 tournament
- `pred_valid`  in  1  conditional branch in predict stage
- `pred_pc`  in  32  its PC
- `pred_class`  in  `$clog2(N_CLASS)`  branch class
- `pred_imm_sign`  in  1  offset sign, static prediction
- `pred_taken`  out  1  prediction, combinational
- `res_valid`  in  1  branch at resolve stage, aligned with last metadata stage
- `res_taken`  in  1  actual outcome
- `res_mispredict`  out  1  resolved outcome ≠ stored prediction
- `perf_branches`, `perf_mispred`  out  32 each  saturating counters

## Operation
- Global index: `{ghr_spec, pc_idx}`. Local index: `{lhr_spec[class], pc_idx}`. Meta index: `pc_idx`.
- Taken when counter MSB is 1.
- Mode 3 selects global when the meta MSB is 1, else local.
- `pred_taken` is 0 when `pred_valid` is 0.
- Predict accept requires `pred_valid && !stall && !flush && !res_mispredict`. On accept:
  - shift `pred_taken` into `ghr_spec` and `lhr_spec[class]`;
  - push entry {valid, class, gidx, lidx, midx, g_pred, l_pred, final_pred, imm_sign} into stage 0.
- Each stage advances one step per `!stall` cycle. A non-accepted cycle inserts an invalid entry.
- Resolve takes effect only when `res_valid && !stall` and the last-stage entry is valid.
- On resolve:
  - global PHT and `lhr`-class local PHT counters move ±1 toward `res_taken` using the stored indices, saturating at 0 and 2^W−1;
  - meta is updated only when `g_pred != l_pred`, +1 if global was correct, −1 otherwise;
  - `ghr_commit` and `lhr_commit[class]` shift in `res_taken`;
  - both perf counters update and saturate at 0xFFFF_FFFF.
- Tables train in every mode.
- `res_mispredict` = effective resolve && `res_taken != final_pred`.
- On mispredict or `flush`:
  - all metadata stages are invalidated;
  - speculative histories load commit values including this cycle's resolve shift (`{commit[W-2:0], res_taken}`).
- `flush` without resolve restores to the current commit values.

## Timing
- Predict is 0-cycle combinational from `pred_pc`, `pred_class`, `mode` and the current histories.
- Tables have asynchronous read, write at the clock edge, and no bypass. A same-cycle predict of an index being trained reads the old value.
- Resolve occurs exactly `PIPE_DEPTH` advancing cycles after predict.
- Simultaneous predict and mispredict/flush: the predict is dropped and histories are restored.
- Simultaneous resolve and `flush` without mispredict: training still happens, then the flush restore.
- Reset (asynchronous, any cycle):
  - PHTs = `CNT_INIT`;
  - meta = 2^(META_W−1) (weakly global);
  - all histories 0;
  - stage valids 0;
  - perf counters 0;
  - `res_mispredict` 0.
- History wrap: shift left, dropping the MSB.

## Structure
- Package `bp_pkg`:
  - mode enum `BP_STATIC`/`BP_GLOBAL`/`BP_LOCAL`/`BP_TOURN`;
  - metadata entry struct;
  - `sat_inc`/`sat_dec` functions.
- Sub-module `bp_pht`, parametrised on index width, counter width and init value, with one read port and one train port. It is instantiated for the global PHT, the meta table, and `N_CLASS` times via generate for the local PHTs.

## Test plan
- Reset, mode 3, predict pc 0x100 class 0 → `pred_taken` = 0 (`CNT_INIT` 0). Predict again after one accept → `ghr_spec` = 0.
- Mode 0, `pred_imm_sign` = 1 → `pred_taken` = 1. With `pred_imm_sign` = 0 → 0, regardless of tables.
- Mode 1, loop branch at pc 0x200 resolved taken 8 times with `PIPE_DEPTH` = 2 → predictions flip to taken after two trainings of the same index. `perf_branches` = 8, `perf_mispred` equals the counted flips.
- Predict taken, resolve `res_taken` = 0 → `res_mispredict` = 1. Younger in-flight entry is invalidated (its later `res_valid` is ignored). `ghr_spec` = `{ghr_commit[4:0], 0}`.
- `stall` held 3 cycles with `res_valid` = 1 → no counter, history or perf change. Resolve completes on the first unstalled cycle.
- Assert `rst_n` low mid-sequence with pipe full → all valids 0 and perf counters 0 immediately. `pred_taken` for any pc in mode 1 = 0.
